// File: rtl/atm_pkg.sv
// Shared definitions for the ATM transaction controller.
//   state_t   : controller FSM states
//   DIGIT_MAX : largest keypad value accepted as a PIN digit
package atm_pkg;

  typedef enum logic [2:0] {
    ESPERANDO_TARJETA,
    ESPERANDO_PIN,
    USUARIO_IDENTIFICADO,
    DEPOSITO,
    RETIRO,
    BLOQUEADO
  } state_t;

  localparam int DIGIT_MAX = 9;

endpackage

// File: rtl/atm_controller_param_if.sv
// Front-end bundle of the ATM controller.
//   master : keypad/card-reader/host side (drives requests, observes results)
//   slave  : controller side
// Requests: card strobe/type/starting balance, stored PIN, digit strobe,
// transaction type, amount strobe, cancel.
// Results: balance plus status pulses and the warning/lock levels.
interface atm_controller_param_if #(
  parameter int PIN_DIGITS = 4,
  parameter int DIGIT_W    = 4,
  parameter int BAL_W      = 64,
  parameter int MONTO_W    = 32
);

  logic                          tarjeta_recibida;
  logic                          tipo_de_tarjeta;
  logic [BAL_W-1:0]              balance_inicial;
  logic [PIN_DIGITS*DIGIT_W-1:0] pin;
  logic [DIGIT_W-1:0]            digito;
  logic                          digito_stb;
  logic                          tipo_trans;
  logic [MONTO_W-1:0]            monto;
  logic                          monto_stb;
  logic                          cancelar;

  logic [BAL_W-1:0]              balance;
  logic                          balance_actualizado;
  logic                          entregar_dinero;
  logic                          fondos_insuficientes;
  logic                          limite_excedido;
  logic                          pin_incorrecto;
  logic                          advertencia;
  logic                          bloqueo;
  logic                          timeout;

  modport master (
    output tarjeta_recibida, tipo_de_tarjeta, balance_inicial, pin, digito,
           digito_stb, tipo_trans, monto, monto_stb, cancelar,
    input  balance, balance_actualizado, entregar_dinero, fondos_insuficientes,
           limite_excedido, pin_incorrecto, advertencia, bloqueo, timeout
  );

  modport slave (
    input  tarjeta_recibida, tipo_de_tarjeta, balance_inicial, pin, digito,
           digito_stb, tipo_trans, monto, monto_stb, cancelar,
    output balance, balance_actualizado, entregar_dinero, fondos_insuficientes,
           limite_excedido, pin_incorrecto, advertencia, bloqueo, timeout
  );

endinterface

// File: rtl/atm_pin_checker.sv
// PIN entry collector.
//   clk, reset  : clock, asynchronous active-high reset
//   clear       : held by the controller whenever PIN entry is not active
//   digito_stb  : keypad strobe, digito the keyed value (values > 9 dropped)
//   pin         : stored PIN, first digit in the MSBs
//   pin_ok/fail : one-cycle verdict in the cycle after the last digit lands
module atm_pin_checker
  import atm_pkg::*;
#(
  parameter int PIN_DIGITS = 4,
  parameter int DIGIT_W    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          digito_stb,
  input  logic [DIGIT_W-1:0]            digito,
  input  logic [PIN_DIGITS*DIGIT_W-1:0] pin,
  output logic                          pin_ok,
  output logic                          pin_fail
);

  localparam int PW    = PIN_DIGITS * DIGIT_W;
  localparam int CNT_W = $clog2(PIN_DIGITS + 1);

  logic [PW-1:0]    pin_usuario;
  logic [CNT_W-1:0] count;
  logic             full;

  assign full = (count == CNT_W'(PIN_DIGITS));

  // A full register is judged for exactly one cycle and then self-clears,
  // so a retry starts from an empty buffer without controller help.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pin_usuario <= '0;
      count       <= '0;
    end else if (clear || full) begin
      pin_usuario <= '0;
      count       <= '0;
    end else if (digito_stb && (digito <= DIGIT_W'(DIGIT_MAX))) begin
      pin_usuario <= (pin_usuario << DIGIT_W) | PW'(digito);
      count       <= count + 1'b1;
    end
  end

  assign pin_ok   = full && (pin_usuario == pin);
  assign pin_fail = full && (pin_usuario != pin);

endmodule

// File: rtl/atm_controller_param.sv
// ATM transaction controller: card intake with foreign-card fee, PIN entry
// with bounded retries, then one deposit or withdrawal on a local balance.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : front-end bundle (slave side), see atm_controller_param_if
// Every output is a register; status pulses last one cycle.
// Amounts are zero-extended into the balance width (MONTO_W <= BAL_W).
module atm_controller_param
  import atm_pkg::*;
#(
  parameter int PIN_DIGITS    = 4,
  parameter int DIGIT_W       = 4,
  parameter int BAL_W         = 64,
  parameter int MONTO_W       = 32,
  parameter int MAX_INTENTOS  = 3,
  parameter int COMISION      = 1000,
  parameter int LIMITE_RETIRO = 500000,
  parameter int TIMEOUT_CYC   = 1024
) (
  input logic                   clk,
  input logic                   reset,
  atm_controller_param_if.slave bus
);

  localparam int INT_W = $clog2(MAX_INTENTOS + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [BAL_W-1:0] COM = BAL_W'(COMISION);

  state_t           state_reg;
  logic [BAL_W-1:0] balance_reg;
  logic [INT_W-1:0] intentos_reg;
  logic [TMO_W-1:0] tmo_cnt_reg;
  logic             act_reg, entregar_reg, fondos_reg, limite_reg;
  logic             pin_inc_reg, adv_reg, bloqueo_reg, timeout_reg;

  logic             pin_ok, pin_fail;
  logic [BAL_W-1:0] monto_ext;
  logic [BAL_W:0]   suma;
  logic [INT_W-1:0] intentos_inc;
  logic             strobe_any, timed, tmo_hit, cancel_req;

  atm_pin_checker #(
    .PIN_DIGITS (PIN_DIGITS),
    .DIGIT_W    (DIGIT_W)
  ) u_pin (
    .clk        (clk),
    .reset      (reset),
    .clear      (state_reg != ESPERANDO_PIN),
    .digito_stb (bus.digito_stb),
    .digito     (bus.digito),
    .pin        (bus.pin),
    .pin_ok     (pin_ok),
    .pin_fail   (pin_fail)
  );

  assign monto_ext    = BAL_W'(bus.monto);
  assign suma         = {1'b0, balance_reg} + {1'b0, monto_ext};
  assign intentos_inc = intentos_reg + 1'b1;
  assign strobe_any   = bus.tarjeta_recibida | bus.digito_stb | bus.monto_stb;
  assign timed        = (state_reg == ESPERANDO_PIN) || (state_reg == DEPOSITO) ||
                        (state_reg == RETIRO);
  assign tmo_hit      = timed && !strobe_any && (tmo_cnt_reg == TMO_W'(TIMEOUT_CYC - 1));
  assign cancel_req   = bus.cancelar &&
                        ((state_reg == ESPERANDO_PIN) || (state_reg == USUARIO_IDENTIFICADO) ||
                         (state_reg == DEPOSITO) || (state_reg == RETIRO));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ESPERANDO_TARJETA;
      balance_reg  <= '0;
      intentos_reg <= '0;
      tmo_cnt_reg  <= '0;
      act_reg      <= 1'b0;
      entregar_reg <= 1'b0;
      fondos_reg   <= 1'b0;
      limite_reg   <= 1'b0;
      pin_inc_reg  <= 1'b0;
      adv_reg      <= 1'b0;
      bloqueo_reg  <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      act_reg      <= 1'b0;
      entregar_reg <= 1'b0;
      fondos_reg   <= 1'b0;
      limite_reg   <= 1'b0;
      pin_inc_reg  <= 1'b0;
      timeout_reg  <= 1'b0;
      // Every timed state is entered from an untimed one, so this alone
      // restarts the idle count on each state change.
      tmo_cnt_reg  <= (timed && !strobe_any) ? tmo_cnt_reg + 1'b1 : '0;

      if (cancel_req) begin
        state_reg <= ESPERANDO_TARJETA;
      end else if (tmo_hit) begin
        timeout_reg <= 1'b1;
        state_reg   <= ESPERANDO_TARJETA;
      end else begin
        case (state_reg)
          ESPERANDO_TARJETA: begin
            if (bus.tarjeta_recibida) begin
              balance_reg  <= bus.balance_inicial;
              intentos_reg <= '0;
              adv_reg      <= 1'b0;
              if (bus.tipo_de_tarjeta) begin
                if (bus.balance_inicial < COM) begin
                  fondos_reg <= 1'b1;
                end else begin
                  balance_reg <= bus.balance_inicial - COM;
                  state_reg   <= ESPERANDO_PIN;
                end
              end else begin
                state_reg <= ESPERANDO_PIN;
              end
            end
          end
          ESPERANDO_PIN: begin
            if (pin_ok) begin
              intentos_reg <= '0;
              state_reg    <= USUARIO_IDENTIFICADO;
            end else if (pin_fail) begin
              pin_inc_reg  <= 1'b1;
              intentos_reg <= intentos_inc;
              if (intentos_inc == INT_W'(MAX_INTENTOS)) begin
                bloqueo_reg <= 1'b1;
                state_reg   <= BLOQUEADO;
              end else if (intentos_inc == INT_W'(MAX_INTENTOS - 1)) begin
                adv_reg <= 1'b1;
              end
            end
          end
          USUARIO_IDENTIFICADO: begin
            state_reg <= bus.tipo_trans ? RETIRO : DEPOSITO;
          end
          DEPOSITO: begin
            if (bus.monto_stb) begin
              balance_reg <= suma[BAL_W] ? {BAL_W{1'b1}} : suma[BAL_W-1:0];
              act_reg     <= 1'b1;
              state_reg   <= ESPERANDO_TARJETA;
            end
          end
          RETIRO: begin
            if (bus.monto_stb) begin
              if (bus.monto > MONTO_W'(LIMITE_RETIRO)) begin
                limite_reg <= 1'b1;
              end else if (monto_ext > balance_reg) begin
                fondos_reg <= 1'b1;
              end else begin
                balance_reg  <= balance_reg - monto_ext;
                act_reg      <= 1'b1;
                entregar_reg <= 1'b1;
              end
              state_reg <= ESPERANDO_TARJETA;
            end
          end
          BLOQUEADO: begin
            bloqueo_reg <= 1'b1;
          end
          default: state_reg <= ESPERANDO_TARJETA;
        endcase
      end
    end
  end

  assign bus.balance              = balance_reg;
  assign bus.balance_actualizado  = act_reg;
  assign bus.entregar_dinero      = entregar_reg;
  assign bus.fondos_insuficientes = fondos_reg;
  assign bus.limite_excedido      = limite_reg;
  assign bus.pin_incorrecto       = pin_inc_reg;
  assign bus.advertencia          = adv_reg;
  assign bus.bloqueo              = bloqueo_reg;
  assign bus.timeout              = timeout_reg;

endmodule

// File: tb/tb_atm_controller_param.sv
// Self-checking bench for atm_controller_param: directed scenarios followed
// by randomized sessions scored against an arithmetic account model.
module tb_atm_controller_param;

  localparam int PIN_DIGITS    = 4;
  localparam int DIGIT_W       = 4;
  localparam int BAL_W         = 64;
  localparam int MONTO_W       = 32;
  localparam int MAX_INTENTOS  = 3;
  localparam int COMISION      = 1000;
  localparam int LIMITE_RETIRO = 500000;
  localparam int TIMEOUT_CYC   = 40;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  atm_controller_param_if #(
    .PIN_DIGITS(PIN_DIGITS), .DIGIT_W(DIGIT_W), .BAL_W(BAL_W), .MONTO_W(MONTO_W)
  ) bus ();

  atm_controller_param #(
    .PIN_DIGITS(PIN_DIGITS), .DIGIT_W(DIGIT_W), .BAL_W(BAL_W), .MONTO_W(MONTO_W),
    .MAX_INTENTOS(MAX_INTENTOS), .COMISION(COMISION),
    .LIMITE_RETIRO(LIMITE_RETIRO), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] outs();
    return {bus.balance, bus.balance_actualizado, bus.entregar_dinero,
            bus.fondos_insuficientes, bus.limite_excedido, bus.pin_incorrecto,
            bus.advertencia, bus.bloqueo, bus.timeout};
  endfunction

  task automatic insert_card(input bit foreign, input logic [63:0] bal);
    @(negedge clk);
    bus.tarjeta_recibida = 1'b1;
    bus.tipo_de_tarjeta  = foreign;
    bus.balance_inicial  = bal;
    @(negedge clk);
    bus.tarjeta_recibida = 1'b0;
  endtask

  task automatic key(input logic [3:0] d);
    @(negedge clk);
    bus.digito     = d;
    bus.digito_stb = 1'b1;
    @(negedge clk);
    bus.digito_stb = 1'b0;
  endtask

  // Leaves the bench one negedge after the verdict edge.
  task automatic enter_pin(input logic [15:0] p);
    for (int i = 3; i >= 0; i--) key(p[i*4 +: 4]);
    @(negedge clk);
  endtask

  task automatic amount(input logic [31:0] m, input bit with_cancel);
    @(negedge clk);
    bus.monto     = m;
    bus.monto_stb = 1'b1;
    bus.cancelar  = with_cancel;
    @(negedge clk);
    bus.monto_stb = 1'b0;
    bus.cancelar  = 1'b0;
  endtask

  task automatic cancel_pulse();
    @(negedge clk);
    bus.cancelar = 1'b1;
    @(negedge clk);
    bus.cancelar = 1'b0;
  endtask

  // Account model: outcome of one session straight from the account rules.
  task automatic session(input string name, input bit foreign, input logic [63:0] bal_ini,
                         input logic [15:0] p, input bit good_pin, input bit withdraw,
                         input logic [31:0] amt);
    logic [63:0] exp_bal;
    logic [64:0] sum;
    bit exp_act, exp_ent, exp_fi, exp_lim;
    bus.pin        = p;
    bus.tipo_trans = withdraw;
    insert_card(foreign, bal_ini);
    if (foreign && bal_ini < 64'(COMISION)) begin
      check({name, "/fee_insufficient"}, 64'(bus.fondos_insuficientes), 64'd1);
      $display("txn %s: foreign card bal=%0d below fee", name, bal_ini);
      return;
    end
    exp_bal = foreign ? bal_ini - 64'(COMISION) : bal_ini;
    check({name, "/card_fi"}, 64'(bus.fondos_insuficientes), 64'd0);
    check({name, "/card_balance"}, bus.balance, exp_bal);
    enter_pin(good_pin ? p : (p ^ 16'h1000));
    check({name, "/pin_incorrecto"}, 64'(bus.pin_incorrecto), 64'(!good_pin));
    if (!good_pin) begin
      cancel_pulse();
      $display("txn %s: wrong pin, cancelled", name);
      return;
    end
    exp_act = 0; exp_ent = 0; exp_fi = 0; exp_lim = 0;
    if (!withdraw) begin
      sum = 65'(exp_bal) + 65'(amt);
      exp_bal = (sum > 65'({64{1'b1}})) ? {64{1'b1}} : sum[63:0];
      exp_act = 1;
    end else if (amt > 32'(LIMITE_RETIRO)) begin
      exp_lim = 1;
    end else if (64'(amt) > exp_bal) begin
      exp_fi = 1;
    end else begin
      exp_bal = exp_bal - 64'(amt);
      exp_act = 1;
      exp_ent = 1;
    end
    amount(amt, 1'b0);
    check({name, "/balance"}, bus.balance, exp_bal);
    check({name, "/actualizado"}, 64'(bus.balance_actualizado), 64'(exp_act));
    check({name, "/entregar"}, 64'(bus.entregar_dinero), 64'(exp_ent));
    check({name, "/fondos"}, 64'(bus.fondos_insuficientes), 64'(exp_fi));
    check({name, "/limite"}, 64'(bus.limite_excedido), 64'(exp_lim));
    @(negedge clk);
    check({name, "/pulse_width"}, 64'({bus.balance_actualizado, bus.entregar_dinero,
                                      bus.fondos_insuficientes, bus.limite_excedido}), 64'd0);
    $display("txn %s: foreign=%0d ini=%0d %s amt=%0d -> bal=%0d", name, foreign, bal_ini,
             withdraw ? "withdraw" : "deposit", amt, bus.balance);
  endtask

  initial begin
    int first_tmo;
    int tmo_pulses;
    bus.tarjeta_recibida = 0; bus.tipo_de_tarjeta = 0; bus.balance_inicial = '0;
    bus.pin = 16'h1234; bus.digito = '0; bus.digito_stb = 0; bus.tipo_trans = 0;
    bus.monto = '0; bus.monto_stb = 0; bus.cancelar = 0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'(outs() != 72'd0), 64'd0);
    reset = 1'b0;
    $display("txn reset: outputs cleared");

    session("local_deposit", 0, 64'd5000, 16'h1234, 1, 0, 32'd700);
    session("foreign_withdraw_all", 1, 64'd5000, 16'h1234, 1, 1, 32'd4000);
    session("over_limit", 0, 64'd1000000, 16'h1234, 1, 1, 32'd600000);
    session("at_limit", 0, 64'd1000000, 16'h1234, 1, 1, 32'd500000);
    session("insufficient", 0, 64'd1000, 16'h1234, 1, 1, 32'd2000);
    session("saturate", 0, 64'hFFFF_FFFF_FFFF_FF00, 16'h9087, 1, 0, 32'd500);
    session("fee_too_big", 1, 64'd500, 16'h1234, 1, 0, 32'd10);

    // Out-of-range digit is dropped without counting.
    bus.pin = 16'h1234; bus.tipo_trans = 0;
    insert_card(0, 64'd2000);
    key(4'd1); key(4'hA); key(4'd2); key(4'd3); key(4'd4);
    @(negedge clk);
    check("digit_a_pin_ok", 64'(bus.pin_incorrecto), 64'd0);
    amount(32'd50, 1'b0);
    check("digit_a_deposit", bus.balance, 64'd2050);
    $display("txn digit_a: balance=%0d", bus.balance);

    // Cancel beats a same-cycle amount strobe.
    insert_card(0, 64'd3000);
    enter_pin(16'h1234);
    amount(32'd500, 1'b1);
    check("cancel_no_update", 64'(bus.balance_actualizado), 64'd0);
    check("cancel_balance", bus.balance, 64'd3000);
    amount(32'd500, 1'b0);
    check("cancel_idle_ignores_monto", 64'(bus.balance_actualizado), 64'd0);
    $display("txn cancel: balance=%0d", bus.balance);

    // Lockout after repeated wrong PINs.
    insert_card(0, 64'd5000);
    for (int k = 1; k <= MAX_INTENTOS; k++) begin
      enter_pin(16'h4321);
      check($sformatf("wrong%0d_pulse", k), 64'(bus.pin_incorrecto), 64'd1);
      check($sformatf("wrong%0d_adv", k), 64'(bus.advertencia), 64'(k >= MAX_INTENTOS - 1));
      check($sformatf("wrong%0d_bloqueo", k), 64'(bus.bloqueo), 64'(k == MAX_INTENTOS));
      $display("txn wrong_pin %0d: adv=%0d bloqueo=%0d", k, bus.advertencia, bus.bloqueo);
    end
    enter_pin(16'h1234);
    amount(32'd100, 1'b0);
    check("blocked_no_update", 64'(bus.balance_actualizado), 64'd0);
    check("blocked_balance", bus.balance, 64'd5000);
    insert_card(0, 64'd9);
    check("blocked_card_ignored", bus.balance, 64'd5000);
    check("blocked_level", 64'(bus.bloqueo), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("reset_clears_bloqueo", 64'(bus.bloqueo), 64'd0);
    $display("txn unblock: bloqueo=%0d", bus.bloqueo);

    // Inactivity timeout during PIN entry.
    insert_card(0, 64'd700);
    first_tmo = 0; tmo_pulses = 0;
    for (int k = 1; k <= TIMEOUT_CYC + 10; k++) begin
      @(negedge clk);
      if (bus.timeout) begin
        tmo_pulses++;
        if (first_tmo == 0) first_tmo = k;
      end
    end
    check("timeout_cycle", 64'(first_tmo), 64'(TIMEOUT_CYC));
    check("timeout_single_pulse", 64'(tmo_pulses), 64'd1);
    enter_pin(16'h1234);
    check("timeout_back_to_idle", 64'(bus.pin_incorrecto), 64'd0);
    $display("txn timeout: at cycle %0d", first_tmo);

    // Asynchronous reset in the middle of a withdrawal.
    bus.tipo_trans = 1;
    insert_card(0, 64'd8000);
    enter_pin(16'h1234);
    @(negedge clk);
    check("pre_reset_balance", bus.balance, 64'd8000);
    #2 reset = 1'b1;
    #1 check("async_reset_outputs", 64'(outs() != 72'd0), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    amount(32'd100, 1'b0);
    check("after_reset_idle", 64'(bus.entregar_dinero), 64'd0);
    $display("txn async_reset: outputs cleared");

    // Randomized sessions.
    for (int n = 0; n < 24; n++) begin
      logic [15:0] p;
      logic [63:0] bi;
      logic [31:0] amt;
      bit w;
      for (int i = 0; i < 4; i++) p[i*4 +: 4] = 4'($urandom_range(0, 9));
      bi  = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 1999))
                                        : 64'($urandom_range(0, 1000000));
      w   = 1'($urandom_range(0, 1));
      amt = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 700000))
                                        : 32'($urandom_range(0, 3000));
      session($sformatf("rand%0d", n), 1'($urandom_range(0, 1)), bi, p,
              $urandom_range(0, 3) != 0, w, amt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
